wb_regfile: RTL and testbench

Write-back stage and architectural register file, directly downstream of the EX/WB pipeline register. Consumes the EX/WB outputs (bank select, ALU/mux result, PC, destination address, instruction-valid) and commits the selected value into a 16×32 register file. Provides two asynchronous read ports with same-cycle write bypass to the decode stage, plus a retired-instruction counter and a sticky illegal-select flag.

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_regfile_16x32.sv | 30 +++
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 126 ++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and write-back select encoding
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  typedef enum logic [1:0] {
    WB_NONE   = 2'b00,
    WB_RESULT = 2'b01,
    WB_LINK   = 2'b10,
    WB_RSVD   = 2'b11
  } wb_sel_e;
endpackage

// File: rtl/wb_regfile_regfile_16x32.sv
// regfile_16x32: register storage with one write port and two raw async read ports
module regfile_16x32
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int NREG = 1 << ADDR_W;
  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '0;
    else mem_q <= mem_d;
  end
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, register commit with bypass, retire counter, illegal-select flag
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        regs_bank_in,
  input  logic [DATA_W-1:0] mux2_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] regC_adress_in,
  input  logic              write_inst_in,
  input  logic [ADDR_W-1:0] regA_adress,
  input  logic [ADDR_W-1:0] regB_adress,
  output logic [DATA_W-1:0] regA_data,
  output logic [DATA_W-1:0] regB_data,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_adress,
  output logic [31:0]       retired_count,
  output logic              illegal_bank
);
  wb_sel_e sel;
  logic we;
  logic [DATA_W-1:0] wdata, raw_a, raw_b;
  logic [31:0] retired_q, retired_d;
  logic illegal_q, illegal_d, wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_adress_q, wb_adress_d;
  assign sel = wb_sel_e'(regs_bank_in);
  regfile_16x32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(regC_adress_in), .wdata(wdata),
    .raddr_a(regA_adress), .raddr_b(regB_adress), .rdata_a(raw_a), .rdata_b(raw_b)
  );
  // reads are forced to zero while reset is held so decode never sees stale state
  always_comb begin
    wdata = (sel == WB_LINK) ? pc_in : mux2_in;
    we = write_inst_in && (sel == WB_RESULT || sel == WB_LINK) && (regC_adress_in != '0);
    regA_data = (!rst_n || regA_adress == '0) ? '0 :
                (we && regA_adress == regC_adress_in) ? wdata : raw_a;
    regB_data = (!rst_n || regB_adress == '0) ? '0 :
                (we && regB_adress == regC_adress_in) ? wdata : raw_b;
    retired_d = retired_q + 32'(write_inst_in);
    illegal_d = illegal_q | (write_inst_in && sel == WB_RSVD);
    wb_valid_d = we;
    wb_adress_d = regC_adress_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_adress_q <= '0;
    end else begin
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
      wb_valid_q  <= wb_valid_d;
      wb_adress_q <= wb_adress_d;
    end
  end
  assign retired_count = retired_q;
  assign illegal_bank = illegal_q;
  assign wb_valid = wb_valid_q;
  assign wb_adress = wb_adress_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scoreboard bench for wb_regfile
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] regs_bank_in;
  logic [31:0] mux2_in, pc_in, regA_data, regB_data, retired_count;
  logic [3:0] regC_adress_in, regA_adress, regB_adress, wb_adress;
  logic write_inst_in, wb_valid, illegal_bank;
  typedef enum {S_RA, S_RB, S_CNT, S_ILL, S_WBV} sig_e;
  typedef struct {string name; sig_e sig; logic [31:0] exp;} chk_t;
  typedef struct {int cyc; logic [3:0] adr;} wb_t;
  chk_t chk_q[$];
  wb_t wb_q[$];
  int checks = 0, errors = 0, cyc = 0;
  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .regs_bank_in(regs_bank_in), .mux2_in(mux2_in),
    .pc_in(pc_in), .regC_adress_in(regC_adress_in), .write_inst_in(write_inst_in),
    .regA_adress(regA_adress), .regB_adress(regB_adress), .regA_data(regA_data),
    .regB_data(regB_data), .wb_valid(wb_valid), .wb_adress(wb_adress),
    .retired_count(retired_count), .illegal_bank(illegal_bank)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    chk_t c;
    wb_t w;
    logic [31:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      act = c.sig == S_RA ? regA_data : c.sig == S_RB ? regB_data :
            c.sig == S_CNT ? retired_count : c.sig == S_ILL ? {31'b0, illegal_bank} : {31'b0, wb_valid};
      cmp(c.name, act, c.exp);
    end
    if (wb_valid === 1'b1) begin
      if (wb_q.size() == 0) cmp("wb_valid_unexpected", 32'd1, 32'd0);
      else begin
        w = wb_q.pop_front();
        cmp("wb_adress", {28'b0, wb_adress}, {28'b0, w.adr});
        cmp("wb_latency", cyc, w.cyc + 1);
      end
    end else if (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
      w = wb_q.pop_front();
      cmp("wb_valid_missing", {31'b0, wb_valid}, 32'd1);
    end
  end
  task automatic step(input logic rn, input logic [1:0] sel, input logic [31:0] mux, input logic [31:0] pc,
                      input logic [3:0] c, input logic wi, input logic [3:0] ra, input logic [3:0] rb);
    rst_n = rn; regs_bank_in = sel; mux2_in = mux; pc_in = pc;
    regC_adress_in = c; write_inst_in = wi; regA_adress = ra; regB_adress = rb;
  endtask
  task automatic ex(input string n, input sig_e s, input logic [31:0] v);
    chk_q.push_back('{n, s, v});
  endtask
  task automatic ex_wb(input logic [3:0] a);
    wb_q.push_back('{cyc, a});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);
    tick; tick;
    step(1, 2'b01, 32'h55, 0, 3, 1, 3, 0);
    ex("pre_reset_bypass", S_RA, 32'h55); ex("pre_reset_rb0", S_RB, 0); ex_wb(3); tick;
    step(0, 2'b01, 32'h77, 0, 4, 1, 3, 4);
    ex("read_during_reset", S_RA, 0); ex("cnt_before_reset", S_CNT, 1); tick;
    step(1, 2'b00, 0, 0, 0, 0, 3, 4);
    ex("reset_reg3", S_RA, 0); ex("reset_reg4", S_RB, 0); ex("reset_cnt", S_CNT, 0);
    ex("reset_ill", S_ILL, 0); ex("reset_wbv", S_WBV, 0); tick;
    step(1, 2'b01, 32'd200, 0, 9, 1, 9, 0);
    ex("result_bypass", S_RA, 200); ex("r0_read", S_RB, 0); ex("cnt0", S_CNT, 0); ex_wb(9); tick;
    step(1, 2'b00, 0, 0, 0, 0, 9, 0);
    ex("result_stored", S_RA, 200); ex("cnt1", S_CNT, 1); tick;
    step(1, 2'b10, 32'd123, 32'd450, 12, 1, 12, 9);
    ex("link_bypass", S_RA, 450); ex("link_rb9", S_RB, 200); ex_wb(12); tick;
    step(1, 2'b00, 32'd999, 0, 12, 1, 12, 0);
    ex("none_no_bypass", S_RA, 450); ex("cnt2", S_CNT, 2); tick;
    step(1, 2'b00, 0, 0, 0, 0, 12, 0);
    ex("link_stored", S_RA, 450); ex("none_counted", S_CNT, 3); ex("none_no_wbv", S_WBV, 0); tick;
    step(1, 2'b01, 32'hFFFF, 0, 0, 1, 0, 0);
    ex("r0_write_ra", S_RA, 0); ex("r0_write_rb", S_RB, 0); tick;
    step(1, 2'b01, 32'hABC, 0, 9, 0, 9, 0);
    ex("gated_no_bypass", S_RA, 200); ex("r0_cnt", S_CNT, 4); ex("r0_no_wbv", S_WBV, 0); tick;
    step(1, 2'b00, 0, 0, 0, 0, 9, 0);
    ex("gated_no_write", S_RA, 200); ex("gated_no_count", S_CNT, 4); ex("gated_no_wbv", S_WBV, 0); tick;
    step(1, 2'b11, 32'hDEAD, 32'hBEEF, 9, 1, 9, 0);
    ex("rsvd_no_bypass", S_RA, 200); ex("ill_not_yet", S_ILL, 0); tick;
    step(1, 2'b01, 32'd31, 0, 7, 1, 9, 7);
    ex("rsvd_no_write", S_RA, 200); ex("after_rsvd_bypass", S_RB, 31);
    ex("ill_set", S_ILL, 1); ex("rsvd_counted", S_CNT, 5); ex_wb(7); tick;
    step(1, 2'b00, 0, 0, 0, 0, 7, 0);
    ex("reg7", S_RA, 31); ex("ill_sticky", S_ILL, 1); ex("cnt6", S_CNT, 6); tick;
    step(1, 2'b01, 32'd160, 0, 5, 1, 5, 0);
    ex("b2b_first_bypass", S_RA, 160); ex_wb(5); tick;
    step(1, 2'b01, 32'd620, 0, 5, 1, 5, 5);
    ex("b2b_second_bypass_a", S_RA, 620); ex("b2b_second_bypass_b", S_RB, 620); ex_wb(5); tick;
    step(1, 2'b00, 0, 0, 0, 0, 5, 0);
    ex("b2b_last_wins", S_RA, 620); ex("cnt8", S_CNT, 8); ex("ill_still", S_ILL, 1); tick;
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    step(1, 2'b00, 0, 0, 0, 1, 5, 0);
    ex("cnt_preload", S_CNT, 32'hFFFF_FFFE); tick;
    step(1, 2'b00, 0, 0, 0, 1, 5, 0);
    ex("cnt_max", S_CNT, 32'hFFFF_FFFF); tick;
    step(1, 2'b00, 0, 0, 0, 0, 5, 0);
    ex("cnt_wrap", S_CNT, 0); tick;
    step(0, 2'b01, 32'd5, 0, 5, 1, 5, 9);
    ex("ill_before_reset", S_ILL, 1); ex("read_in_reset", S_RA, 0); tick;
    step(1, 2'b00, 0, 0, 0, 0, 5, 9);
    ex("reset2_reg5", S_RA, 0); ex("reset2_reg9", S_RB, 0);
    ex("ill_cleared", S_ILL, 0); ex("reset2_cnt", S_CNT, 0); tick;
    tick;
    cmp("wb_queue_drained", wb_q.size(), 0);
    cmp("chk_queue_drained", chk_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
